// File: rtl/sortmax_locked_p.sv
// Streaming max/argmax over N samples with a key lock: once enough wrong-key runs
// have completed, later wrong-key runs quietly search for the minimum instead.
module sortmax_locked_p #(
  parameter int                W             = 8,
  parameter int                N             = 8,
  parameter int                KEY_W         = 4,
  parameter logic [KEY_W-1:0]  KEY_VAL       = 4'hA,
  parameter int                CORRUPT_AFTER = 4,
  localparam int               IW            = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KEY_W-1:0] keyinput,
  input  logic [W-1:0]  din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  max_out,
  output logic [IW-1:0] idx_out
);

  localparam int CW  = $clog2(N + 1);
  localparam int WRW = $clog2(CORRUPT_AFTER + 1) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CMP   = 3'd2,
    CMP_D = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state, state_d;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   run_max, nxt_max;
  logic [IW-1:0]  run_idx, nxt_idx;
  logic [WRW-1:0] wrong_runs;
  logic           key_ok;
  logic           xfer, last, min_mode, upd;

  assign din_ready = (state == LOAD) || (state == CMP) || (state == CMP_D);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign xfer      = din_valid && din_ready;
  assign last      = (cnt == CW'(N - 1));
  assign min_mode  = (wrong_runs >= WRW'(CORRUPT_AFTER));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    else     state <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d = state;
    upd     = 1'b0;
    nxt_max = run_max;
    nxt_idx = run_idx;
    case (state)
      IDLE: if (start) state_d = LOAD;
      LOAD: if (xfer) begin
        nxt_max = din;
        nxt_idx = '0;
        if (N == 1)      state_d = DONE;
        else if (key_ok) state_d = CMP;
        else             state_d = CMP_D;
      end
      CMP, CMP_D: if (xfer) begin
        // Wrong-key runs past the threshold flip the comparison; timing is unchanged.
        if (state == CMP_D && min_mode) upd = (din < run_max);
        else                            upd = (din > run_max);
        if (upd) begin
          nxt_max = din;
          nxt_idx = IW'(cnt);
        end
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      run_max    <= '0;
      run_idx    <= '0;
      max_out    <= '0;
      idx_out    <= '0;
      wrong_runs <= '0;
      key_ok     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt    <= '0;
          key_ok <= (keyinput == KEY_VAL);
        end
        LOAD:       if (xfer) cnt <= CW'(1);
        CMP, CMP_D: if (xfer) cnt <= cnt + 1'b1;
        default: ;
      endcase
      if (xfer) begin
        run_max <= nxt_max;
        run_idx <= nxt_idx;
      end
      // Results latch only on entry to DONE and hold through later runs.
      if (state_d == DONE && state != DONE) begin
        max_out <= nxt_max;
        idx_out <= nxt_idx;
        if (!key_ok && wrong_runs != '1) wrong_runs <= wrong_runs + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sortmax_locked_p.sv
// Directed bench for sortmax_locked_p (N=4, W=8, KEY_VAL=4'hA, CORRUPT_AFTER=2):
// a vector table of full runs plus hand sequences for gaps, mid-run reset and held start.
module tb_sortmax_locked_p;

  logic       clk = 1'b0;
  logic       rst, start, din_valid;
  logic [3:0] keyinput;
  logic [7:0] din;
  logic       din_ready, busy, done;
  logic [7:0] max_out;
  logic [1:0] idx_out;

  int checks   = 0;
  int failures = 0;
  logic [7:0] prev_max;
  logic [1:0] prev_idx;

  typedef struct {
    logic [3:0]      key;
    logic [3:0][7:0] d;     // d[3] is the first sample
    logic [7:0]      emax;
    logic [1:0]      eidx;
  } vec_t;

  vec_t tbl [10];

  sortmax_locked_p #(
    .W(8), .N(4), .KEY_W(4), .KEY_VAL(4'hA), .CORRUPT_AFTER(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .keyinput(keyinput),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .busy(busy), .done(done), .max_out(max_out), .idx_out(idx_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One run: start on a negedge, samples on following negedges, optional
  // 3-cycle valid gap before sample gap_at; done must appear right after the 4th transfer.
  task automatic run_vec(input string tag, input logic [3:0] key, input logic [3:0][7:0] d,
                         input int gap_at, input logic [7:0] emax, input logic [1:0] eidx);
    @(negedge clk);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    start = 1'b1; keyinput = key; din_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; keyinput = key ^ 4'hF;
    check({tag, ".run_busy"}, 32'(busy), 32'd1);
    check({tag, ".hold_max"}, 32'(max_out), 32'(prev_max));
    check({tag, ".hold_idx"}, 32'(idx_out), 32'(prev_idx));
    for (int i = 0; i < 4; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          check({tag, ".gap_ready"}, 32'(din_ready), 32'd1);
          din_valid = 1'b0; din = 8'hFF;
          @(negedge clk);
        end
      end
      check({tag, ".ready"}, 32'(din_ready), 32'd1);
      din_valid = 1'b1; din = d[3-i];
      @(negedge clk);
    end
    din_valid = 1'b0;
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".done_busy"}, 32'(busy), 32'd1);
    check({tag, ".max"}, 32'(max_out), 32'(emax));
    check({tag, ".idx"}, 32'(idx_out), 32'(eidx));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    prev_max = emax;
    prev_idx = eidx;
  endtask

  initial begin
    tbl[0] = '{4'hA, {8'd5, 8'd9,   8'd9, 8'd3},   8'd9,   2'd1};
    tbl[1] = '{4'hA, {8'd1, 8'd2,   8'd3, 8'd4},   8'd4,   2'd3};
    tbl[2] = '{4'hA, {8'd8, 8'd8,   8'd8, 8'd8},   8'd8,   2'd0};
    tbl[3] = '{4'hA, {8'd0, 8'd0,   8'd0, 8'd255}, 8'd255, 2'd3};
    tbl[4] = '{4'h3, {8'd2, 8'd7,   8'd1, 8'd4},   8'd7,   2'd1};
    tbl[5] = '{4'h3, {8'd2, 8'd7,   8'd1, 8'd4},   8'd7,   2'd1};
    tbl[6] = '{4'h3, {8'd2, 8'd7,   8'd1, 8'd4},   8'd1,   2'd2};
    tbl[7] = '{4'hA, {8'd2, 8'd7,   8'd1, 8'd4},   8'd7,   2'd1};
    tbl[8] = '{4'h3, {8'd9, 8'd3,   8'd5, 8'd3},   8'd3,   2'd1};
    tbl[9] = '{4'h3, {8'd4, 8'd4,   8'd6, 8'd2},   8'd2,   2'd3};

    rst = 1'b1; start = 1'b0; keyinput = 4'h0; din = 8'h0; din_valid = 1'b0;
    prev_max = 8'd0; prev_idx = 2'd0;
    repeat (2) @(negedge clk);
    check("reset.max", 32'(max_out), 32'd0);
    check("reset.idx", 32'(idx_out), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.ready", 32'(din_ready), 32'd0);
    rst = 1'b0;

    for (int r = 0; r < 4; r++)
      run_vec($sformatf("vec%0d", r), tbl[r].key, tbl[r].d, -1, tbl[r].emax, tbl[r].eidx);

    run_vec("gap", 4'hA, {8'd5, 8'd9, 8'd9, 8'd3}, 2, 8'd9, 2'd1);

    for (int r = 4; r < 10; r++)
      run_vec($sformatf("vec%0d", r), tbl[r].key, tbl[r].d, -1, tbl[r].emax, tbl[r].eidx);

    // Reset after the second transfer of a wrong-key run.
    @(negedge clk);
    start = 1'b1; keyinput = 4'h3;
    @(negedge clk);
    start = 1'b0; din_valid = 1'b1; din = 8'd2;
    @(negedge clk);
    din = 8'd7;
    @(negedge clk);
    din_valid = 1'b0; rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rstmid.done", 32'(done), 32'd0);
    check("rstmid.busy", 32'(busy), 32'd0);
    check("rstmid.ready", 32'(din_ready), 32'd0);
    check("rstmid.max", 32'(max_out), 32'd0);
    check("rstmid.idx", 32'(idx_out), 32'd0);
    prev_max = 8'd0; prev_idx = 2'd0;
    run_vec("postrst", 4'h3, {8'd2, 8'd7, 8'd1, 8'd4}, -1, 8'd7, 2'd1);

    // start held high through a whole run, then one cycle of IDLE, then a new run.
    @(negedge clk);
    start = 1'b1; keyinput = 4'hA;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("hold.ready", 32'(din_ready), 32'd1);
      din_valid = 1'b1;
      din = (i == 1) ? 8'd200 : 8'd10;
      @(negedge clk);
    end
    din_valid = 1'b0;
    check("hold.done", 32'(done), 32'd1);
    check("hold.max", 32'(max_out), 32'd200);
    check("hold.idx", 32'(idx_out), 32'd1);
    @(negedge clk);
    check("hold.idle_busy", 32'(busy), 32'd0);
    check("hold.idle_done", 32'(done), 32'd0);
    @(negedge clk);
    check("hold.restart_busy", 32'(busy), 32'd1);
    check("hold.restart_ready", 32'(din_ready), 32'd1);
    check("hold.restart_done", 32'(done), 32'd0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din_valid = 1'b1;
      din = 8'(i + 1);
      @(negedge clk);
    end
    din_valid = 1'b0;
    check("hold2.done", 32'(done), 32'd1);
    check("hold2.max", 32'(max_out), 32'd4);
    check("hold2.idx", 32'(idx_out), 32'd3);
    @(negedge clk);
    check("hold2.done_pulse", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sortmax_locked_p.md
SORTMAX_LOCKED_P -- requirements
Module: sortmax_locked_p

Interface
REQ-001 Parameter W, default 8: sample width in bits (W >= 2).
REQ-002 Parameter N, default 8: samples per run (N >= 1).
REQ-003 Parameter KEY_W, default 4: key width in bits.
REQ-004 Parameter KEY_VAL, default 4'hA: correct key value.
REQ-005 Parameter CORRUPT_AFTER, default 4: number of wrong-key runs that complete correctly before corruption starts.
REQ-006 The block SHALL use one clock, clk, and a synchronous active-high reset, rst.
REQ-007 Ports SHALL be:
- clk  in  1  clock, all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a run; acted on only in IDLE.
- keyinput  in  KEY_W  lock key; sampled on an accepted start.
- din  in  W  sample data, unsigned.
- din_valid  in  1  din holds a valid sample.
- din_ready  out  1  block accepts a sample this cycle.
- busy  out  1  a run is in progress, i.e. the state is not IDLE.
- done  out  1  one-cycle pulse when a run finishes.
- max_out  out  W  result value.
- idx_out  out  IW  result index, where IW = max(1, clog2(N)).

Function
REQ-008 The FSM states SHALL be IDLE, LOAD, CMP, CMP_D and DONE, binary encoded; any illegal state SHALL go to IDLE on the next cycle.
REQ-009 IDLE SHALL drive din_ready=0 and busy=0, and SHALL ignore din_valid.
REQ-010 IDLE with start=1 SHALL go to LOAD, clear cnt, and register key_ok = (keyinput == KEY_VAL).
REQ-011 A sample transfer SHALL occur when din_valid=1 and din_ready=1 on the same clock edge; din_ready SHALL be 1 in LOAD, CMP and CMP_D, and 0 elsewhere.
REQ-012 LOAD with no transfer SHALL hold LOAD.
REQ-013 A LOAD transfer SHALL set run_max=din, run_idx=0 and cnt=1, then go:
- to DONE if N=1;
- else to CMP if key_ok=1;
- else to CMP_D.
REQ-014 A CMP transfer SHALL update run_max=din and run_idx=cnt only when din > run_max (strictly greater); on a tie the earlier index is kept.
REQ-015 Every CMP or CMP_D transfer SHALL increment cnt; the transfer made with cnt = N-1 SHALL go to DONE.
REQ-016 CMP_D SHALL follow the CMP handshake, counting and compare rule while wrong_runs < CORRUPT_AFTER.
REQ-017 When wrong_runs >= CORRUPT_AFTER, CMP_D SHALL update only when din < run_max (a minimum search); the handshake, counting and timing SHALL stay identical to CMP.
REQ-018 wrong_runs SHALL be a saturating counter of width clog2(CORRUPT_AFTER+1)+1.
- It increments on each DONE entered from a run with key_ok=0.
- It is never cleared except by rst.
- A correct-key run does not change it.
REQ-019 DONE SHALL last exactly one cycle, then go to IDLE.
- done=1 in that cycle only.
- max_out and idx_out load run_max and run_idx on entry to DONE.
REQ-020 max_out and idx_out SHALL hold their values until the next DONE or rst; they SHALL NOT change during a later run.
REQ-021 Latency: done SHALL assert exactly one cycle after the N-th transfer edge, so a run with continuous din_valid lasts N+2 cycles from start to done.
REQ-022 start while busy=1 SHALL be ignored, and keyinput changes during a run SHALL have no effect.
REQ-023 In DONE, start SHALL be ignored; a new run needs start in IDLE.
REQ-024 busy SHALL be 1 in LOAD, CMP, CMP_D and DONE.

Reset
REQ-025 rst=1 at a rising edge SHALL force, on that edge:
- state=IDLE;
- cnt=0, run_max=0, run_idx=0;
- max_out=0, idx_out=0;
- wrong_runs=0, key_ok=0;
- done=0, din_ready=0, busy=0.
REQ-026 rst asserted mid-run SHALL abort the run with no done pulse; the outputs SHALL read 0 on the next cycle.
REQ-027 rst SHALL take priority over all other inputs.

Verification (N=4, W=8, KEY_VAL=4'hA, CORRUPT_AFTER=2)
REQ-028 Correct key, din = 5, 9, 9, 3 with continuous valid -> done 6 cycles after start, max_out=9, idx_out=1.
REQ-029 Correct key, din_valid low for 3 cycles between samples 2 and 3 -> din_ready stays 1, there is no extra transfer, and the result is unchanged.
REQ-030 Key 4'h3, three consecutive runs of din = 2, 7, 1, 4 -> runs 1 and 2 give max_out=7, idx_out=1; run 3 gives max_out=1, idx_out=2.
REQ-031 After the three wrong-key runs, a run with key 4'hA on din = 2, 7, 1, 4 -> max_out=7, idx_out=1; the corruption state persists for later wrong-key runs.
REQ-032 rst pulsed after the second transfer of a run -> no done pulse, max_out=0, busy=0 next cycle, wrong_runs=0; then a key 4'h3 run gives a correct max.
REQ-033 start held high through a whole run -> exactly one run and one done pulse, then a new run begins the cycle after return to IDLE.
